// File: rtl/not_checker.sv
// not_checker: self-checking monitor for an inverter bus.
//
// It delays the stimulus `a` by LAT cycles to line it up with the
// inverter's settled output `y`. In every RUN cycle it compares `y`
// against the inverted, delayed stimulus and updates the run statistics.
//
// Parameters:
//   WIDTH - inverter bus width
//   LAT   - cycles from a change of `a` to settled `y` (0..15)
//   CNT_W - width of every counter
//
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   start, stop     - run control, sampled every cycle
//   a, y            - inverter stimulus and inverter output
//   busy, done      - registered state flags (FILL/RUN, DONE)
//   pass            - run verdict, meaningful while done is high
//   err_pulse       - one cycle high after each mismatching comparison
//   chk_cnt         - comparisons made in the current run
//   err_cnt         - mismatches in the current run
//   first_err_idx   - chk_cnt at the first mismatch (all-ones if none)
//   tgl_cnt         - RUN cycles with y changed from the previous cycle;
//                     present only when NOT_CHECKER_TOGGLE_CNT_EN is defined
module not_checker #(
    parameter int WIDTH = 1,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
`ifdef NOT_CHECKER_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] tgl_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // With no latency the delay line is empty, so a start goes straight to RUN.
    localparam logic [1:0] START_ST  = (LAT == 0) ? RUN : FILL;
    // The FILL counter counts down to zero, which gives LAT FILL cycles.
    localparam logic [3:0] FILL_INIT = 4'((LAT > 0) ? LAT - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [3:0]       fill_q, fill_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] a_d;

`ifdef NOT_CHECKER_TOGGLE_CNT_EN
    logic [WIDTH-1:0] y_prev_q;
    logic [CNT_W-1:0] tgl_q, tgl_d;
`endif

    // Stimulus delay line. It shifts in every state, so a_d is already
    // valid when the run leaves FILL.
    generate
        if (LAT == 0) begin : g_nodly
            assign a_d = a;
        end else begin : g_dly
            logic [LAT-1:0][WIDTH-1:0] dly_q, dly_d;

            always_comb begin
                dly_d[0] = a;
                for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dly_q <= '0;
                else        dly_q <= dly_d;
            end

            assign a_d = dly_q[LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        chk_d   = chk_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        pulse_d = 1'b0;
`ifdef NOT_CHECKER_TOGGLE_CNT_EN
        tgl_d   = tgl_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // stop is ignored here, so start+stop behaves as a start
                if (start) begin
                    state_d = START_ST;
                    fill_d  = FILL_INIT;
                    chk_d   = '0;
                    err_d   = '0;
                    fidx_d  = '1;
`ifdef NOT_CHECKER_TOGGLE_CNT_EN
                    tgl_d   = '0;
`endif
                end
            end
            FILL: begin
                // A stop during FILL ends the run without any comparison.
                if (stop)                state_d = DONE;
                else if (fill_q == 4'd0) state_d = RUN;
                else                     fill_d  = fill_q - 4'd1;
            end
            RUN: begin
                // The cycle that carries stop is still a RUN cycle and is compared.
                if (chk_q != '1) chk_d = chk_q + 1'b1;
                if (y != ~a_d) begin
                    pulse_d = 1'b1;
                    if (err_q != '1) err_d = err_q + 1'b1;
                    // A zero err_cnt means this is the first mismatch of the run.
                    if (err_q == '0) fidx_d = chk_q;
                end
`ifdef NOT_CHECKER_TOGGLE_CNT_EN
                if (y != y_prev_q && tgl_q != '1) tgl_d = tgl_q + 1'b1;
`endif
                if (stop) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // The flags are computed from the next state, so they change on the
        // same edge as the state.
        busy_d = (state_d == FILL) || (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0) && (chk_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fill_q  <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef NOT_CHECKER_TOGGLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_prev_q <= '0;
            tgl_q    <= '0;
        end else begin
            y_prev_q <= y;
            tgl_q    <= tgl_d;
        end
    end

    assign tgl_cnt = tgl_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_pulse     = pulse_q;
    assign chk_cnt       = chk_q;
    assign err_cnt       = err_q;
    assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_not_checker.sv
// Testbench for not_checker. It runs three instances side by side:
//   u0: WIDTH=1, LAT=1, CNT_W=16
//   u1: WIDTH=8, LAT=3, CNT_W=16
//   u2: WIDTH=1, LAT=0, CNT_W=4
// A behavioural model predicts the outputs of every instance after each
// clock edge and pushes the prediction into a scoreboard queue. A monitor
// pops the queue on the falling edge and compares. Directed scenarios also
// check key results against fixed constants.
module tb_not_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [7:0] a     = '0;
    logic       y0    = 1'b0;
    logic       y2    = 1'b0;
    logic [7:0] y1    = '0;

    logic [2:0]  busy_w, done_w, pass_w, pulse_w;
    logic [15:0] chk0, err0, fi0, chk1, err1, fi1;
    logic [3:0]  chk2, err2, fi2;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    not_checker #(.WIDTH(1), .LAT(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .a(a[0:0]), .y(y0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_pulse(pulse_w[0]),
        .chk_cnt(chk0), .err_cnt(err0), .first_err_idx(fi0));

    not_checker #(.WIDTH(8), .LAT(3), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .a(a), .y(y1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_pulse(pulse_w[1]),
        .chk_cnt(chk1), .err_cnt(err1), .first_err_idx(fi1));

    not_checker #(.WIDTH(1), .LAT(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .a(a[0:0]), .y(y2),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_pulse(pulse_w[2]),
        .chk_cnt(chk2), .err_cnt(err2), .first_err_idx(fi2));

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_FILL, M_RUN, M_DONE} mode_t;

    typedef struct {
        int          k;
        bit          busy, done, pass, pulse;
        int unsigned chk, err, fidx;
    } exp_t;

    exp_t sb[$];

    int          lat_k [3] = '{1, 3, 0};
    int          cw_k  [3] = '{16, 16, 4};
    bit [7:0]    wm_k  [3] = '{8'h01, 8'hFF, 8'h01};

    mode_t       md    [3];
    int          rem   [3];
    int unsigned m_chk [3], m_err [3], m_fidx [3];
    bit          m_pls [3];
    bit [7:0]    hist  [3][16];  // hist[k][0] = a of the previous cycle

    function automatic int unsigned maxv(int k);
        return (32'd1 << cw_k[k]) - 32'd1;
    endfunction

    function automatic bit [7:0] ad_of(int k, bit [7:0] av);
        bit [7:0] r;
        r = (lat_k[k] == 0) ? av : hist[k][lat_k[k]-1];
        return r & wm_k[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            md[k] = M_IDLE; rem[k] = 0; m_chk[k] = 0; m_err[k] = 0;
            m_fidx[k] = maxv(k); m_pls[k] = 1'b0;
            for (int i = 0; i < 16; i++) hist[k][i] = '0;
        end
    endtask

    task automatic model_step(int k, bit st, bit sp, bit [7:0] av, bit [7:0] yv);
        bit [7:0] ad;
        exp_t     e;
        ad = ad_of(k, av);
        m_pls[k] = 1'b0;
        case (md[k])
            M_IDLE, M_DONE:
                if (st) begin
                    m_chk[k] = 0; m_err[k] = 0; m_fidx[k] = maxv(k);
                    if (lat_k[k] == 0) md[k] = M_RUN;
                    else begin md[k] = M_FILL; rem[k] = lat_k[k]; end
                end
            M_FILL:
                if (sp) md[k] = M_DONE;
                else begin
                    rem[k]--;
                    if (rem[k] == 0) md[k] = M_RUN;
                end
            M_RUN: begin
                if (((yv ^ ~ad) & wm_k[k]) != 0) begin
                    if (m_err[k] == 0) m_fidx[k] = m_chk[k];
                    if (m_err[k] < maxv(k)) m_err[k]++;
                    m_pls[k] = 1'b1;
                end
                if (m_chk[k] < maxv(k)) m_chk[k]++;
                if (sp) md[k] = M_DONE;
            end
            default: md[k] = M_IDLE;
        endcase
        for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = av;
        e.k = k;
        e.busy = (md[k] == M_FILL) || (md[k] == M_RUN);
        e.done = (md[k] == M_DONE);
        e.pass = (md[k] == M_DONE) && (m_err[k] == 0) && (m_chk[k] != 0);
        e.pulse = m_pls[k];
        e.chk = m_chk[k]; e.err = m_err[k]; e.fidx = m_fidx[k];
        sb.push_back(e);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    task automatic get_act(int k, output logic b, output logic d, output logic p,
                           output logic e, output logic [31:0] c,
                           output logic [31:0] er, output logic [31:0] fi);
        b = busy_w[k]; d = done_w[k]; p = pass_w[k]; e = pulse_w[k];
        case (k)
            0:       begin c = {16'b0, chk0}; er = {16'b0, err0}; fi = {16'b0, fi0}; end
            1:       begin c = {16'b0, chk1}; er = {16'b0, err1}; fi = {16'b0, fi1}; end
            default: begin c = {28'b0, chk2}; er = {28'b0, err2}; fi = {28'b0, fi2}; end
        endcase
    endtask

    task automatic cmp(int k, bit eb, bit ed, bit ep, bit ee,
                       int unsigned ec, int unsigned eer, int unsigned efi);
        logic b, d, p, e;
        logic [31:0] c, er, fi;
        get_act(k, b, d, p, e, c, er, fi);
        check("busy", k, {31'b0, b}, {31'b0, eb});
        check("done", k, {31'b0, d}, {31'b0, ed});
        check("pass", k, {31'b0, p}, {31'b0, ep});
        check("err_pulse", k, {31'b0, e}, {31'b0, ee});
        check("chk_cnt", k, c, ec);
        check("err_cnt", k, er, eer);
        check("first_err_idx", k, fi, efi);
    endtask

    task automatic reset_chk(int k);
        cmp(k, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, maxv(k));
    endtask

    // Monitor: the outputs of all instances are valid every cycle, so each
    // prediction pushed at a rising edge is compared on the next falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.k, e.busy, e.done, e.pass, e.pulse, e.chk, e.err, e.fidx);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs. y of each instance is the correct inverted,
    // delayed stimulus XOR a per-instance corruption mask.
    task automatic step(bit st, bit sp, bit [7:0] av, bit [7:0] f0, bit [7:0] f1, bit [7:0] f2);
        bit [7:0] yy [3];
        yy[0] = (~ad_of(0, av) ^ f0) & wm_k[0];
        yy[1] = (~ad_of(1, av) ^ f1) & wm_k[1];
        yy[2] = (~ad_of(2, av) ^ f2) & wm_k[2];
        start = st; stop = sp; a = av;
        y0 = yy[0][0]; y1 = yy[1]; y2 = yy[2][0];
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, st, sp, av, yy[k]);
        #1;
    endtask

    // Start, one FILL cycle for u0, then 8 RUN cycles on u0 with stop on the
    // last one. a toggles 0,1,0,... from the FILL cycle onwards. With bad=1,
    // u0's y is corrupted on its 3rd RUN cycle, where the correct value is 1.
    task automatic run_a(bit bad);
        step(1'b1, 1'b0, 8'h00, 8'h0, 8'h0, 8'h0);
        step(1'b0, 1'b0, 8'h00, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i == 7), ((i + 1) % 2 == 1) ? 8'h01 : 8'h00,
                 (bad && i == 2) ? 8'h01 : 8'h00, 8'h0, 8'h0);
            if (i == 2) check("err_pulse_on", 0, {31'b0, pulse_w[0]}, {31'b0, bad});
            if (i == 3) check("err_pulse_off", 0, {31'b0, pulse_w[0]}, 32'd0);
        end
        check("run_done", 0, {31'b0, done_w[0]}, 32'd1);
        check("run_chk", 0, {16'b0, chk0}, 32'd8);
        if (bad) begin
            check("run_err", 0, {16'b0, err0}, 32'd1);
            check("run_fidx", 0, {16'b0, fi0}, 32'd2);
            check("run_pass", 0, {31'b0, pass_w[0]}, 32'd0);
        end else begin
            check("run_err", 0, {16'b0, err0}, 32'd0);
            check("run_fidx", 0, {16'b0, fi0}, 32'h0000FFFF);
            check("run_pass", 0, {31'b0, pass_w[0]}, 32'd1);
        end
    endtask

    // A stop during FILL of the LAT=3 instance leads to DONE with nothing counted.
    task automatic run_c();
        step(1'b1, 1'b0, 8'h5A, 8'h0, 8'h0, 8'h0);
        step(1'b0, 1'b1, 8'hA5, 8'h0, 8'h0, 8'h0);
        check("fillstop_done", 1, {31'b0, done_w[1]}, 32'd1);
        check("fillstop_busy", 1, {31'b0, busy_w[1]}, 32'd0);
        check("fillstop_chk", 1, {16'b0, chk1}, 32'd0);
        check("fillstop_pass", 1, {31'b0, pass_w[1]}, 32'd0);
    endtask

    // Every comparison wrong for more than 15 RUN cycles: the 4-bit counters saturate.
    task automatic run_e();
        for (int i = 0; i < 22; i++)
            step((i == 0), (i == 21), 8'($urandom), 8'hFF, 8'hFF, 8'hFF);
        check("sat_chk", 2, {28'b0, chk2}, 32'd15);
        check("sat_err", 2, {28'b0, err2}, 32'd15);
        check("sat_fidx", 2, {28'b0, fi2}, 32'd0);
        check("sat_pass", 2, {31'b0, pass_w[2]}, 32'd0);
    endtask

    // Reset is pulled low between clock edges during a run.
    task automatic midrun_reset();
        step(1'b1, 1'b0, 8'h00, 8'h0, 8'h0, 8'h0);
        step(1'b0, 1'b0, 8'h01, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'($urandom), 8'h0, 8'h0, 8'h0);
        check("midrun_chk", 0, {16'b0, chk0}, 32'd5);
        #6;                       // past the falling edge, before the next rising edge
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) reset_chk(k);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // start+stop together: acts as a start in IDLE and as a stop in RUN.
    task automatic run_f();
        step(1'b1, 1'b1, 8'h00, 8'h0, 8'h0, 8'h0);
        check("ss_idle_busy", 0, {31'b0, busy_w[0]}, 32'd1);
        check("ss_idle_done", 0, {31'b0, done_w[0]}, 32'd0);
        step(1'b0, 1'b0, 8'h01, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom), 8'h0, 8'h0, 8'h0);
        step(1'b1, 1'b1, 8'h00, 8'h0, 8'h0, 8'h0);
        check("ss_run_done", 0, {31'b0, done_w[0]}, 32'd1);
        check("ss_run_chk", 0, {16'b0, chk0}, 32'd4);
        check("ss_run_fidx", 0, {16'b0, fi0}, 32'h0000FFFF);
        check("ss_run_pass", 0, {31'b0, pass_w[0]}, 32'd1);
    endtask

    initial begin
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) reset_chk(k);
        #1 rst_n = 1'b1;

        run_a(1'b0);
        run_a(1'b1);
        run_c();
        run_e();
        midrun_reset();
        run_f();
        run_a(1'b0);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0), 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0,
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0,
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 0, sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
